// File: rtl/ddr_tx_serializer_pkg.sv
// Shared types and constants for the DDR transmit serializer.
// Optional preamble selected by DDR_TX_PREAMBLE_EN (see ddr_tx_serializer.sv).
package ddr_tx_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } state_t;

    localparam int PRE_CYCLES     = 2;
    localparam int BITS_PER_CYCLE = 2;
    localparam int BYTE_CYCLES    = 4;

    // Bit pair for byte cycle k, MSB first: {byte[7-2k], byte[6-2k]}.
    function automatic logic [1:0] pair_at(input logic [7:0] b, input logic [1:0] k);
        logic [7:0] s;
        s = b << (BITS_PER_CYCLE * int'(k));
        return s[7:6];
    endfunction

endpackage

// File: rtl/ddr_tx_serializer.sv
// Byte-to-DDR-pair serializer feeding the odp/odn/oen inputs of the DDR pad wrapper.
// Define DDR_TX_PREAMBLE_EN to insert a 2-cycle (0,1) preamble before every burst.
module ddr_tx_serializer
    import ddr_tx_serializer_pkg::*;
#(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       odp,
    output logic       odn,
    output logic       oen,
    output logic       busy,
    output logic       underrun
);

    state_t     r_state;
    logic [1:0] r_cnt;
    logic       r_starve;
    logic [7:0] r_shift;
    logic       r_shift_last;
    logic [7:0] r_hold;
    logic       r_hold_last;
    logic       r_hold_full;
    logic       r_odp;
    logic       r_odn;
    logic       r_oen;
    logic       r_underrun;

    state_t     w_state_next;
    logic [1:0] w_cnt_next;
    logic       w_starve_next;
    logic [7:0] w_shift_next;
    logic       w_shift_last_next;
    logic       w_load;
    logic       w_start;
    logic       w_odp_next;
    logic       w_odn_next;
    logic       w_oen_next;
    logic       w_underrun_next;
    logic       w_accept;

    assign w_accept = tx_valid & ~r_hold_full;

    // Pad outputs are computed for the state being entered, so they appear on the edge of the transition.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_starve_next     = r_starve;
        w_shift_next      = r_shift;
        w_shift_last_next = r_shift_last;
        w_load            = 1'b0;
        w_start           = 1'b0;
        w_odp_next        = IDLE_LVL;
        w_odn_next        = IDLE_LVL;
        w_oen_next        = 1'b1;
        w_underrun_next   = r_underrun;

        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_start         = 1'b1;
                    w_underrun_next = 1'b0;
                end
            end
`ifdef DDR_TX_PREAMBLE_EN
            ST_PRE: begin
                w_oen_next = 1'b0;
                if (r_cnt == 2'(PRE_CYCLES - 1)) begin
                    w_state_next               = ST_DATA;
                    w_cnt_next                 = 2'd0;
                    {w_odp_next, w_odn_next}   = pair_at(r_shift, 2'd0);
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                    w_odp_next = 1'b0;
                    w_odn_next = 1'b1;
                end
            end
`endif
            ST_DATA: begin
                w_oen_next = 1'b0;
                if (!r_starve && r_cnt != 2'(BYTE_CYCLES - 1)) begin
                    w_cnt_next               = r_cnt + 2'd1;
                    {w_odp_next, w_odn_next} = pair_at(r_shift, r_cnt + 2'd1);
                end else if (!r_starve && r_shift_last) begin
                    w_state_next = ST_POST;
                end else if (r_hold_full) begin
                    w_load                   = 1'b1;
                    w_starve_next            = 1'b0;
                    w_cnt_next               = 2'd0;
                    {w_odp_next, w_odn_next} = pair_at(r_hold, 2'd0);
                end else begin
                    w_starve_next   = 1'b1;
                    w_underrun_next = 1'b1;
                end
            end
            ST_POST: begin
                if (r_hold_full) begin
                    w_start = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_start) begin
            w_load        = 1'b1;
            w_cnt_next    = 2'd0;
            w_starve_next = 1'b0;
            w_oen_next    = 1'b0;
`ifdef DDR_TX_PREAMBLE_EN
            w_state_next  = ST_PRE;
            w_odp_next    = 1'b0;
            w_odn_next    = 1'b1;
`else
            w_state_next  = ST_DATA;
            {w_odp_next, w_odn_next} = pair_at(r_hold, 2'd0);
`endif
        end

        if (w_load) begin
            w_shift_next      = r_hold;
            w_shift_last_next = r_hold_last;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_starve     <= 1'b0;
            r_shift      <= 8'd0;
            r_shift_last <= 1'b0;
            r_hold       <= 8'd0;
            r_hold_last  <= 1'b0;
            r_hold_full  <= 1'b0;
            r_odp        <= IDLE_LVL;
            r_odn        <= IDLE_LVL;
            r_oen        <= 1'b1;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_starve     <= w_starve_next;
            r_shift      <= w_shift_next;
            r_shift_last <= w_shift_last_next;
            r_odp        <= w_odp_next;
            r_odn        <= w_odn_next;
            r_oen        <= w_oen_next;
            r_underrun   <= w_underrun_next;
            // Accept and load are exclusive: accept needs an empty holding register, load a full one.
            if (w_accept) begin
                r_hold      <= tx_data;
                r_hold_last <= tx_last;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign tx_ready = ~r_hold_full;
    assign busy     = (r_state != ST_IDLE);
    assign odp      = r_odp;
    assign odn      = r_odn;
    assign oen      = r_oen;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Directed self-checking bench for ddr_tx_serializer; expectations adapt to DDR_TX_PREAMBLE_EN.
module tb_ddr_tx_serializer;

`ifdef DDR_TX_PREAMBLE_EN
    localparam int P = 2;
`else
    localparam int P = 0;
`endif
    localparam int TR = 4096;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, odp, odn, oen, busy, underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Trace entry per cycle: {odp, odn, oen, busy}
    logic [3:0] tr_pad [0:TR-1];
    logic       tr_rdy [0:TR-1];
    logic       tr_und [0:TR-1];
    logic [3:0] exp_q [$];

    ddr_tx_serializer #(.IDLE_LVL(1'b0)) dut (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .odp(odp), .odn(odn), .oen(oen), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs after posedge number c are recorded at index c on the following negedge.
    always @(negedge clk) begin
        if (cyc < TR) begin
            tr_pad[cyc] <= {odp, odn, oen, busy};
            tr_rdy[cyc] <= tx_ready;
            tr_und[cyc] <= underrun;
        end
    end

    task automatic push_pair(input logic p, input logic n);
        exp_q.push_back({p, n, 1'b0, 1'b1});
    endtask
    task automatic push_pre();
        for (int i = 0; i < P; i++) exp_q.push_back(4'b0101);
    endtask
    task automatic push_gap();
        exp_q.push_back(4'b0001);
    endtask
    task automatic push_idle();
        exp_q.push_back(4'b0010);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; returns the posedge number on which the byte was accepted.
    task automatic send(input logic [7:0] d, input logic l, output int e);
        int t;
        t = 0;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout byte=%h tx_ready=%b required=1", d, tx_ready);
        end
        e = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #11;
        n_checks++; if (oen !== 1'b1)      begin n_fail++; $display("FAIL reset_oen got=%b required=1", oen); end
        n_checks++; if (odp !== 1'b0)      begin n_fail++; $display("FAIL reset_odp got=%b required=0", odp); end
        n_checks++; if (odn !== 1'b0)      begin n_fail++; $display("FAIL reset_odn got=%b required=0", odn); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b required=1", tx_ready); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b required=0", busy); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%b required=0", underrun); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_a5();
        int e;
        send(8'hA5, 1'b1, e);
        exp_q.delete();
        push_pre();
        push_pair(1, 0); push_pair(1, 0); push_pair(0, 1); push_pair(0, 1);
        push_gap(); push_idle(); push_idle();
        wait_until(e + 1 + exp_q.size());
        n_checks++; if (tr_rdy[e] !== 1'b0) begin n_fail++; $display("FAIL a5_ready_after_accept got=%b required=0", tr_rdy[e]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (tr_pad[e + 1 + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL a5_stream cycle=%0d {odp,odn,oen,busy} got=%b required=%b", i, tr_pad[e + 1 + i], exp_q[i]);
            end
        end
        $display("test_single_a5 accepted at edge %0d", e);
    endtask

    task automatic test_single_80();
        int e;
        send(8'h80, 1'b1, e);
        exp_q.delete();
        push_pre();
        push_pair(1, 0); push_pair(0, 0); push_pair(0, 0); push_pair(0, 0);
        push_gap(); push_idle();
        wait_until(e + 1 + exp_q.size());
        n_checks++; if (tr_pad[e] !== 4'b0010) begin n_fail++; $display("FAIL x80_idle_at_accept got=%b required=0010", tr_pad[e]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (tr_pad[e + 1 + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL x80_stream cycle=%0d {odp,odn,oen,busy} got=%b required=%b", i, tr_pad[e + 1 + i], exp_q[i]);
            end
        end
        $display("test_single_80 accepted at edge %0d", e);
    endtask

    task automatic test_back_to_back();
        int e1, e2, e3;
        send(8'h12, 1'b0, e1);
        send(8'h34, 1'b0, e2);
        send(8'h56, 1'b1, e3);
        exp_q.delete();
        push_pre();
        push_pair(0, 0); push_pair(0, 1); push_pair(0, 0); push_pair(1, 0);
        push_pair(0, 0); push_pair(1, 1); push_pair(0, 1); push_pair(0, 0);
        push_pair(0, 1); push_pair(0, 1); push_pair(0, 1); push_pair(1, 0);
        push_gap(); push_idle();
        wait_until(e1 + 1 + exp_q.size());
        n_checks++; if (tr_rdy[e2] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_hold_full got=%b required=0", tr_rdy[e2]); end
        n_checks++; if (tr_rdy[e3] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_last_full got=%b required=0", tr_rdy[e3]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (tr_pad[e1 + 1 + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_stream cycle=%0d {odp,odn,oen,busy} got=%b required=%b", i, tr_pad[e1 + 1 + i], exp_q[i]);
            end
        end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun got=%b required=0", underrun); end
        $display("test_back_to_back accepted at edges %0d %0d %0d", e1, e2, e3);
    endtask

    task automatic test_underrun();
        int e1, e2;
        send(8'hFF, 1'b0, e1);
        wait_until(e1 + 6 + P);
        send(8'h00, 1'b1, e2);
        exp_q.delete();
        push_pre();
        push_pair(1, 1); push_pair(1, 1); push_pair(1, 1); push_pair(1, 1);
        push_gap(); push_gap(); push_gap();
        push_pair(0, 0); push_pair(0, 0); push_pair(0, 0); push_pair(0, 0);
        push_gap(); push_idle();
        wait_until(e1 + 1 + exp_q.size());
        n_checks++; if (e2 !== e1 + 7 + P) begin n_fail++; $display("FAIL und_accept_edge got=%0d required=%0d", e2, e1 + 7 + P); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (tr_pad[e1 + 1 + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL und_stream cycle=%0d {odp,odn,oen,busy} got=%b required=%b", i, tr_pad[e1 + 1 + i], exp_q[i]);
            end
        end
        n_checks++; if (tr_und[e1 + 4 + P] !== 1'b0) begin n_fail++; $display("FAIL und_before_starve got=%b required=0", tr_und[e1 + 4 + P]); end
        n_checks++; if (tr_und[e1 + 5 + P] !== 1'b1) begin n_fail++; $display("FAIL und_on_starve got=%b required=1", tr_und[e1 + 5 + P]); end
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL und_sticky got=%b required=1", underrun); end
        $display("test_underrun accepted at edges %0d %0d", e1, e2);
    endtask

    task automatic test_two_bursts();
        int e1, e2;
        send(8'hC3, 1'b1, e1);
        send(8'h5A, 1'b1, e2);
        exp_q.delete();
        push_pre();
        push_pair(1, 1); push_pair(0, 0); push_pair(0, 0); push_pair(1, 1);
        push_gap();
        push_pre();
        push_pair(0, 1); push_pair(0, 1); push_pair(1, 0); push_pair(1, 0);
        push_gap(); push_idle();
        wait_until(e1 + 1 + exp_q.size());
        n_checks++; if (tr_und[e1] !== 1'b1) begin n_fail++; $display("FAIL bursts_und_in_idle got=%b required=1", tr_und[e1]); end
        n_checks++; if (tr_und[e1 + 1] !== 1'b0) begin n_fail++; $display("FAIL bursts_und_cleared got=%b required=0", tr_und[e1 + 1]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (tr_pad[e1 + 1 + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bursts_stream cycle=%0d {odp,odn,oen,busy} got=%b required=%b", i, tr_pad[e1 + 1 + i], exp_q[i]);
            end
        end
        $display("test_two_bursts accepted at edges %0d %0d", e1, e2);
    endtask

    task automatic test_reset_mid_burst();
        int e1, e2;
        send(8'h96, 1'b0, e1);
        send(8'h3C, 1'b1, e2);
        wait_until(e1 + 3 + P);
        n_checks++; if ({odp, odn, oen} !== 3'b010) begin n_fail++; $display("FAIL rst_mid_cycle2 {odp,odn,oen} got=%b required=010", {odp, odn, oen}); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold_full got=%b required=0", tx_ready); end
        #2 rstn = 1'b0;
        #1;
        n_checks++; if ({odp, odn, oen} !== 3'b001) begin n_fail++; $display("FAIL rst_mid_async {odp,odn,oen} got=%b required=001", {odp, odn, oen}); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b required=1", tx_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b required=0", busy); end
        n_checks++; if ({odp, odn, oen} !== 3'b001) begin n_fail++; $display("FAIL rst_mid_released {odp,odn,oen} got=%b required=001", {odp, odn, oen}); end
        $display("test_reset_mid_burst accepted at edges %0d %0d", e1, e2);
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_single_80();
        test_back_to_back();
        test_underrun();
        test_two_bursts();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ddr_tx_serializer.md
DDR_TX_SERIALIZER -- requirements
Module: ddr_tx_serializer

Interface
REQ-001 Parameter IDLE_LVL, default 1'b0: level driven on odp/odn whenever no data bit is being sent.
REQ-002 clk  in  1  single clock; all outputs registered on rising edge.
REQ-003 rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 tx_data  in  8  byte to send, MSB first.
REQ-005 tx_valid  in  1  tx_data/tx_last valid.
REQ-006 tx_last  in  1  marks final byte of a burst.
REQ-007 tx_ready  out  1  block can accept a byte this cycle.
REQ-008 odp  out  1  first-half-cycle bit to the DDR pad cell.
REQ-009 odn  out  1  second-half-cycle bit to the DDR pad cell.
REQ-010 oen  out  1  pad output enable, active-low (0 = pad driven).
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 underrun  out  1  sticky flag: data starved mid-burst.

Function
REQ-013 A byte transfers when tx_valid and tx_ready are both high on a rising edge; tx_valid has no effect when tx_ready is low.
REQ-014 Storage is one 8-bit shift register plus one 8-bit holding register (with last bit); tx_ready = holding register empty.
REQ-015 FSM states: IDLE, PRE, DATA, POST.
REQ-016 IDLE: oen=1, odp=odn=IDLE_LVL; when the holding register is full, go to PRE (preamble enabled) or DATA (disabled), moving the byte into the shift register.
REQ-017 PRE: exactly 2 cycles, oen=0, odp=0, odn=1; then DATA.
REQ-018 DATA: 4 cycles per byte; cycle k (k=0..3) drives odp=byte[7-2k], odn=byte[6-2k], oen=0.
REQ-019 At cycle 3 of a byte: if that byte had last, go to POST; else if the holding register is full, load it with no gap; else enter underrun.
REQ-020 Underrun: stay in DATA, oen=0, odp=odn=IDLE_LVL; set underrun; resume at cycle 0 on the first cycle the holding register is full.
REQ-021 POST: 1 cycle, oen=0, odp=odn=IDLE_LVL; then IDLE (or PRE/DATA directly when the holding register is full).
REQ-022 Latency: a byte accepted in IDLE at edge N drives its first bits at N+3 (preamble enabled) or N+1 (disabled).
REQ-023 Sustained bursts of back-to-back valid bytes produce a continuous stream with no idle cycles.
REQ-024 underrun clears on the cycle a new burst leaves IDLE; it is not cleared by resuming inside a burst.
REQ-025 tx_last on a byte is latched with that byte; tx_last with tx_valid low is ignored.

Reset
REQ-026 rstn low asynchronously forces state=IDLE, oen=1, odp=odn=IDLE_LVL, tx_ready=1, busy=0, underrun=0, both registers empty.
REQ-027 Reset mid-burst discards buffered bytes; the pad is released (oen=1) immediately, with no POST cycle.

Configuration
REQ-028 Macro DDR_TX_PREAMBLE_EN defined: the PRE state exists as in REQ-017; undefined: PRE is not compiled, and IDLE/POST go directly to DATA.

Structure
REQ-029 A shared package holds the FSM state enum, PRE_CYCLES=2, BITS_PER_CYCLE=2, and BYTE_CYCLES=4.
REQ-030 Single module, no sub-modules; its outputs connect directly to the odp/odn/oen inputs of the existing DDR pad wrapper.

Verification
REQ-031 Single byte 0xA5 with last, preamble on -> PRE (0,1)x2, then (odp,odn)=(1,0),(1,0),(0,1),(0,1), one POST cycle, oen=1 after.
REQ-032 Three bytes 0x12,0x34,0x56 back-to-back, last on 0x56 -> 12 contiguous DATA cycles, tx_ready low while holding register full, underrun=0.
REQ-033 Burst 0xFF, then valid withheld 3 cycles, then 0x00 with last -> 3 IDLE_LVL cycles with oen=0, underrun=1, 0x00 sent, POST.
REQ-034 Assert rstn low during byte cycle 2 -> same-cycle oen=1, odp=odn=IDLE_LVL; after release, tx_ready=1, busy=0.
REQ-035 Build without DDR_TX_PREAMBLE_EN, send 0x80 with last -> first data (1,0) on the edge after accept, no PRE cycles.
REQ-036 Two single-byte bursts back-to-back -> POST of the first is followed directly by PRE of the second, and oen never goes high between them.
